// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matrix multiplier.
//   state_e         : control FSM encoding (IDLE / FEED / DONE)
//   acc_width()     : default accumulator width, 2*DATA_WIDTH + clog2(N),
//                     wide enough that an N-term dot product never wraps
//   feed_steps()    : number of FEED cycles, 3N-2, for the last operand pair
//                     to reach PE(N-1,N-1)
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FEED = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int acc_width(input int data_width, input int n);
    return 2 * data_width + $clog2(n);
  endfunction

  function automatic int feed_steps(input int n);
    return 3 * n - 2;
  endfunction

endpackage

// File: rtl/systolic_mat_mul_pe.sv
// One processing element of the output-stationary grid.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : accumulate and shift this cycle
//   clr_i         : clear accumulator and pass-through registers (wins over en_i)
//   left_i, up_i  : operands arriving from the west / north neighbour
//   right_o       : left_i registered, to the east neighbour
//   down_o        : up_i registered, to the south neighbour
//   acc_o         : running sum of left_i*up_i, wraps modulo 2^ACC_WIDTH
module systolic_pe #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 66,
  parameter int SIGNED     = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] left_i,
  input  logic [DATA_WIDTH-1:0] up_i,
  output logic [DATA_WIDTH-1:0] right_o,
  output logic [DATA_WIDTH-1:0] down_o,
  output logic [ACC_WIDTH-1:0]  acc_o
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [PW-1:0]         left_ext;
  logic [PW-1:0]         up_ext;
  logic [PW-1:0]         prod;
  logic [ACC_WIDTH-1:0]  prod_ext;
  logic [ACC_WIDTH-1:0]  acc_q;
  logic [DATA_WIDTH-1:0] right_q;
  logic [DATA_WIDTH-1:0] down_q;

  // Extending both operands to PW bits and keeping the low PW bits of the
  // product gives the exact signed or unsigned product, since it fits in PW.
  generate
    if (SIGNED != 0) begin : g_sext
      assign left_ext = {{DATA_WIDTH{left_i[DATA_WIDTH-1]}}, left_i};
      assign up_ext   = {{DATA_WIDTH{up_i[DATA_WIDTH-1]}}, up_i};
    end else begin : g_zext
      assign left_ext = {{DATA_WIDTH{1'b0}}, left_i};
      assign up_ext   = {{DATA_WIDTH{1'b0}}, up_i};
    end
  endgenerate

  assign prod = left_ext * up_ext;

  generate
    if (ACC_WIDTH > PW) begin : g_widen
      assign prod_ext = {{(ACC_WIDTH-PW){(SIGNED != 0) && prod[PW-1]}}, prod};
    end else if (ACC_WIDTH == PW) begin : g_same
      assign prod_ext = prod;
    end else begin : g_narrow
      assign prod_ext = prod[ACC_WIDTH-1:0];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      right_q <= '0;
      down_q  <= '0;
    end else if (clr_i) begin
      acc_q   <= '0;
      right_q <= '0;
      down_q  <= '0;
    end else if (en_i) begin
      acc_q   <= acc_q + prod_ext;
      right_q <= left_i;
      down_q  <= up_i;
    end
  end

  assign acc_o   = acc_q;
  assign right_o = right_q;
  assign down_o  = down_q;

endmodule

// File: rtl/systolic_mat_mul.sv
// N x N output-stationary systolic multiplier, C = A x B.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   start_i         : begin a multiply; accepted on start_i && start_ready_o
//   start_ready_o   : high only in IDLE
//   a_i, b_i        : operand matrices, element (i,j) at [(i*N+j)*DATA_WIDTH +: DATA_WIDTH]
//   busy_o          : high in FEED and DONE
//   res_valid_o     : c_o holds a finished result
//   res_ready_i     : consumer takes c_o on res_valid_o && res_ready_i
//   c_o             : result, element (i,j) at [(i*N+j)*ACC_WIDTH +: ACC_WIDTH]
//   dbg_state_o     : current control state
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer side (start_ready_o, res_valid_o, c_o) never
// depends combinationally on the consumer side, and res_valid_o / c_o stay
// stable until the transfer completes.
module systolic_mat_mul
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 4,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, N),
  parameter int SIGNED     = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  output logic                         start_ready_o,
  input  logic [N*N*DATA_WIDTH-1:0]    a_i,
  input  logic [N*N*DATA_WIDTH-1:0]    b_i,
  output logic                         busy_o,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic [N*N*ACC_WIDTH-1:0]     c_o,
  output state_e                       dbg_state_o
);

  localparam int STEPS = feed_steps(N);
  localparam int CNT_W = $clog2(STEPS + 1);

  state_e                    state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [N*N*DATA_WIDTH-1:0] a_q;
  logic [N*N*DATA_WIDTH-1:0] b_q;
  logic                      start_ready_q;
  logic                      busy_q;
  logic                      res_valid_q;

  logic                      pe_clr;
  logic                      pe_en;
  logic [DATA_WIDTH-1:0]     left_feed [N];
  logic [DATA_WIDTH-1:0]     top_feed  [N];
  logic [DATA_WIDTH-1:0]     hr [N][N-1];
  logic [DATA_WIDTH-1:0]     vr [N-1][N];
  logic [DATA_WIDTH-1:0]     right_unused [N];
  logic [DATA_WIDTH-1:0]     down_unused  [N];

  assign pe_clr = start_i && start_ready_q;
  assign pe_en  = (state_q == ST_FEED);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      res_valid_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q       <= ST_FEED;
            a_q           <= a_i;
            b_q           <= b_i;
            cnt_q         <= '0;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
          end
        end
        ST_FEED: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(STEPS - 1)) begin
            state_q     <= ST_DONE;
            res_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (res_ready_i) begin
            state_q       <= ST_IDLE;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          res_valid_q   <= 1'b0;
          busy_q        <= 1'b0;
          start_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Skew feeder: at step t = cnt_q, row i sees A[i][t-i] and column j sees
  // B[t-j][j]; outside the diagonal band the edge input is zero.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      left_feed[i] = '0;
      top_feed[i]  = '0;
      for (int k = 0; k < N; k++) begin
        if (cnt_q == CNT_W'(i + k)) begin
          left_feed[i] = a_q[(i*N+k)*DATA_WIDTH +: DATA_WIDTH];
          top_feed[i]  = b_q[(k*N+i)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  generate
    for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
        logic [DATA_WIDTH-1:0] left_w;
        logic [DATA_WIDTH-1:0] up_w;
        logic [DATA_WIDTH-1:0] right_w;
        logic [DATA_WIDTH-1:0] down_w;
        logic [ACC_WIDTH-1:0]  acc_w;

        if (j == 0) begin : g_lin
          assign left_w = left_feed[i];
        end else begin : g_lnb
          assign left_w = hr[i][j-1];
        end
        if (i == 0) begin : g_uin
          assign up_w = top_feed[j];
        end else begin : g_unb
          assign up_w = vr[i-1][j];
        end
        // The east and south edges of the grid have no neighbour to feed.
        if (j == N - 1) begin : g_rend
          assign right_unused[i] = right_w;
        end else begin : g_rnb
          assign hr[i][j] = right_w;
        end
        if (i == N - 1) begin : g_dend
          assign down_unused[j] = down_w;
        end else begin : g_dnb
          assign vr[i][j] = down_w;
        end

        systolic_pe #(
          .DATA_WIDTH (DATA_WIDTH),
          .ACC_WIDTH  (ACC_WIDTH),
          .SIGNED     (SIGNED)
        ) u_pe (
          .clk_i   (clk_i),
          .rst_ni  (rst_ni),
          .en_i    (pe_en),
          .clr_i   (pe_clr),
          .left_i  (left_w),
          .up_i    (up_w),
          .right_o (right_w),
          .down_o  (down_w),
          .acc_o   (acc_w)
        );

        assign c_o[(i*N+j)*ACC_WIDTH +: ACC_WIDTH] = acc_w;
      end
    end
  endgenerate

  assign start_ready_o = start_ready_q;
  assign busy_o        = busy_q;
  assign res_valid_o   = res_valid_q;
  assign dbg_state_o   = state_q;

endmodule
